// File: rtl/kv_cache_mem.sv
// Per-layer/per-head K and V vector store with single-vector appends and
// streamed multi-slot reads. Optional per-entry valid bits: KV_VALID_MASK_EN.
module kv_cache_mem #(
    parameter  int MAX_LAYERS = 4,
    parameter  int MAX_HEADS  = 4,
    parameter  int MAX_SEQ    = 512,
    parameter  int HEAD_DIM   = 16,
    parameter  int DW         = 8,
    localparam int VEC_W      = HEAD_DIM * DW,
    localparam int LW         = $clog2(MAX_LAYERS),
    localparam int HW         = $clog2(MAX_HEADS),
    localparam int TW         = $clog2(MAX_SEQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             append_valid,
    output logic             append_ready,
    input  logic [LW-1:0]    append_layer,
    input  logic [HW-1:0]    append_head,
    input  logic [TW-1:0]    append_time,
    input  logic             append_is_v,
    input  logic [VEC_W-1:0] append_data,
    output logic             append_done,
    input  logic             read_req_valid,
    output logic             read_req_ready,
    input  logic [LW-1:0]    read_layer,
    input  logic [HW-1:0]    read_head,
    input  logic [TW-1:0]    read_time_start,
    input  logic [TW-1:0]    read_time_len,
    input  logic             read_is_v,
    output logic             read_data_valid,
    output logic [VEC_W-1:0] read_data,
    output logic             read_data_last,
    output logic             busy
);

    localparam int DEPTH = MAX_LAYERS * MAX_HEADS * MAX_SEQ;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [LW:0] LAYER_LIM = (LW+1)'(MAX_LAYERS);
    localparam logic [HW:0] HEAD_LIM  = (HW+1)'(MAX_HEADS);
    localparam logic [TW:0] SEQ_LIM   = (TW+1)'(MAX_SEQ);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPEND = 2'd1,
        S_READ   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [LW-1:0]    r_layer;
    logic [HW-1:0]    r_head;
    logic [TW-1:0]    r_time;
    logic             r_is_v;
    logic [VEC_W-1:0] r_data;
    logic [TW-1:0]    r_len;
    logic [TW-1:0]    r_cnt;
    logic             r_issue;
    logic             r_append_done;
    logic             r_rd_valid;
    logic             r_rd_last;
    logic [VEC_W-1:0] r_rd_data;

    logic             w_acc_app;
    logic             w_acc_rd;
    logic             w_issue;
    logic             w_write;
    logic             w_last_issue;
    logic             w_in_rng;
    logic             w_ent_vld;
    logic [AW-1:0]    w_addr;
    logic [VEC_W-1:0] w_rd_word;

    logic [VEC_W-1:0] r_kmem [0:DEPTH-1];
    logic [VEC_W-1:0] r_vmem [0:DEPTH-1];

    // Slots at or above MAX_SEQ fold back by one sequence length.
    function automatic logic [TW-1:0] wrap_t(input logic [TW:0] t);
        if (t >= SEQ_LIM) begin
            return TW'(t - SEQ_LIM);
        end else begin
            return TW'(t);
        end
    endfunction

    function automatic logic in_range(input logic [LW:0] l, input logic [HW:0] h);
        return (l < LAYER_LIM) && (h < HEAD_LIM);
    endfunction

    function automatic logic [AW-1:0] entry_addr(input logic [LW-1:0] l,
                                                 input logic [HW-1:0] h,
                                                 input logic [TW-1:0] t);
        int a;
        a = (int'(l) * MAX_HEADS + int'(h)) * MAX_SEQ + int'(t);
        return a[AW-1:0];
    endfunction

    assign w_in_rng     = in_range({1'b0, r_layer}, {1'b0, r_head});
    assign w_addr       = entry_addr(r_layer, r_head, r_time);
    assign w_last_issue = (r_cnt == (r_len - TW'(1)));

    assign append_ready    = (r_state == S_IDLE);
    assign read_req_ready  = (r_state == S_IDLE);
    assign busy            = (r_state != S_IDLE);
    assign append_done     = r_append_done;
    assign read_data_valid = r_rd_valid;
    assign read_data_last  = r_rd_last;
    assign read_data       = r_rd_data;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; append wins over a simultaneous read request.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_app   = 1'b0;
        w_acc_rd    = 1'b0;
        w_issue     = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (append_valid) begin
                    w_acc_app   = 1'b1;
                    w_state_nxt = S_APPEND;
                end else if (read_req_valid) begin
                    w_acc_rd    = 1'b1;
                    w_state_nxt = S_READ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_APPEND: begin
                w_write     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_READ: begin
                // One extra cycle after the final issue lets the last beat drain.
                if (r_issue) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_READ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef KV_VALID_MASK_EN
    logic [DEPTH-1:0] r_kvld;
    logic [DEPTH-1:0] r_vvld;

    // Per-entry written flags, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kvld <= '0;
            r_vvld <= '0;
        end else if (w_write && w_in_rng) begin
            if (r_is_v) begin
                r_vvld[w_addr] <= 1'b1;
            end else begin
                r_kvld[w_addr] <= 1'b1;
            end
        end
    end

    assign w_ent_vld = r_is_v ? r_vvld[w_addr] : r_kvld[w_addr];
`else
    assign w_ent_vld = 1'b1;
`endif

    // Store write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_write && w_in_rng) begin
            if (r_is_v) begin
                r_vmem[w_addr] <= r_data;
            end else begin
                r_kmem[w_addr] <= r_data;
            end
        end
    end

    // Read word selection, zeroed for out-of-range or unwritten entries.
    always_comb begin
        w_rd_word = '0;
        if (w_in_rng && w_ent_vld) begin
            if (r_is_v) begin
                w_rd_word = r_vmem[w_addr];
            end else begin
                w_rd_word = r_kmem[w_addr];
            end
        end else begin
            w_rd_word = '0;
        end
    end

    // Request capture, burst counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_layer       <= '0;
            r_head        <= '0;
            r_time        <= '0;
            r_is_v        <= 1'b0;
            r_data        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_issue       <= 1'b0;
            r_append_done <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_last     <= 1'b0;
            r_rd_data     <= '0;
        end else begin
            r_append_done <= w_acc_app;
            r_rd_valid    <= w_issue;
            r_rd_last     <= w_issue && w_last_issue;
            r_rd_data     <= w_issue ? w_rd_word : '0;
            if (w_acc_app) begin
                r_layer <= append_layer;
                r_head  <= append_head;
                r_time  <= wrap_t({1'b0, append_time});
                r_is_v  <= append_is_v;
                r_data  <= append_data;
            end else if (w_acc_rd) begin
                r_layer <= read_layer;
                r_head  <= read_head;
                r_time  <= wrap_t({1'b0, read_time_start});
                r_is_v  <= read_is_v;
                r_len   <= (read_time_len == '0) ? TW'(1) : read_time_len;
                r_cnt   <= '0;
                r_issue <= 1'b1;
            end else if (w_issue) begin
                r_cnt  <= r_cnt + TW'(1);
                r_time <= wrap_t({1'b0, r_time + TW'(1)});
                if (w_last_issue) begin
                    r_issue <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/kv_cache_mem.md
KV_CACHE_MEM -- requirements
Module: kv_cache_mem

Interface
REQ-001 SHALL have parameters: MAX_LAYERS default 4 (layer count); MAX_HEADS default 4 (heads per layer); MAX_SEQ default 512 (time slots); HEAD_DIM default 16 (elements per vector); DW default 8 (element bits). VEC_W = HEAD_DIM*DW; LW/HW/TW = $clog2(MAX_LAYERS/MAX_HEADS/MAX_SEQ).
REQ-002 SHALL have ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- append_valid  in  1  append request
- append_ready  out  1  append acceptance
- append_layer  in  LW  layer index
- append_head  in  HW  head index
- append_time  in  TW  time slot
- append_is_v  in  1  1 = V store, 0 = K store
- append_data  in  VEC_W  vector to write
- append_done  out  1  one-cycle write-complete pulse
- read_req_valid  in  1  read request
- read_req_ready  out  1  read acceptance
- read_layer  in  LW  layer index
- read_head  in  HW  head index
- read_time_start  in  TW  first time slot
- read_time_len  in  TW  vector count; 0 means 1
- read_is_v  in  1  1 = V store, 0 = K store
- read_data_valid  out  1  streamed vector valid
- read_data  out  VEC_W  streamed vector
- read_data_last  out  1  final vector of a burst
- busy  out  1  not in S_IDLE

Function
REQ-003 SHALL hold two stores, K and V, each MAX_LAYERS*MAX_HEADS*MAX_SEQ entries of VEC_W bits, indexed as (layer*MAX_HEADS + head)*MAX_SEQ + time, with 1-cycle synchronous read.
REQ-004 SHALL implement FSM states S_IDLE, S_APPEND, S_READ; ready outputs SHALL be 1 only in S_IDLE.
REQ-005 In S_IDLE with append_valid=1, SHALL capture all append fields and go to S_APPEND. Append SHALL take priority when both requests are valid in the same cycle.
REQ-006 S_APPEND SHALL last exactly one cycle: write the captured vector at that cycle's clock edge, assert append_done=1, and return to S_IDLE. A held append_valid SHALL NOT cause a second acceptance until S_IDLE is re-entered.
REQ-007 In S_IDLE with read_req_valid=1 and no append request, SHALL capture the read fields and set N = (read_time_len==0) ? 1 : read_time_len.
REQ-008 For a read handshake in cycle C:
- read_data_valid SHALL be 1 in cycles C+2 .. C+1+N, returning slots start, start+1, ... in order.
- read_data_last SHALL be 1 only in cycle C+1+N.
- read_req_ready SHALL be 1 again in cycle C+2+N.
REQ-009 Time slot arithmetic SHALL wrap modulo MAX_SEQ: start + i is truncated to TW bits, and values >= MAX_SEQ wrap by subtracting MAX_SEQ.
REQ-010 Out-of-range requests (layer >= MAX_LAYERS or head >= MAX_HEADS) SHALL be handled as follows:
- append: SHALL NOT write, but SHALL still pulse append_done.
- read: SHALL stream all-zero data with normal timing.
REQ-011 read_data SHALL be 0 whenever read_data_valid=0.
REQ-012 Output values in S_IDLE: append_done=0, read_data_valid=0, read_data_last=0, read_data=0.

Reset
REQ-013 Asserting rst_n low at any time, including mid-burst, SHALL immediately force S_IDLE, abort any in-progress burst, and clear all counters and captured fields.
REQ-014 Output values during and after reset: append_ready=1, read_req_ready=1, append_done=0, read_data_valid=0, read_data_last=0, read_data=0, busy=0.
REQ-015 Store contents SHALL NOT be reset.

Configuration
REQ-016 With macro KV_VALID_MASK_EN defined:
- SHALL keep one valid bit per K entry and per V entry; all bits are cleared on reset.
- A successful append SHALL set the written entry's bit.
- Reads of entries whose bit is clear SHALL return all zeros.
REQ-017 Without KV_VALID_MASK_EN, SHALL have no valid bits; reads return raw store contents, which are undefined until written.

Verification
REQ-018 Append (layer=1, head=2, time=5, is_v=0, data=0x0F..00) -> append_done exactly 1 cycle after the handshake; no second acceptance while append_valid is held.
REQ-019 Then read (1, 2, start=5, len=0, is_v=0) -> single beat 2 cycles after the handshake with data=0x0F..00 and last=1; the same read with is_v=1 -> V data, or zeros with the macro.
REQ-020 Append slots 510, 511, 0; then read start=510, len=3 -> 3 consecutive beats in wrap order 510, 511, 0; last on beat 3; ready high the next cycle.
REQ-021 append_valid and read_req_valid asserted in the same cycle -> append is served first; the read is accepted after append_done and returns the newly written data.
REQ-022 rst_n asserted during beat 2 of a 4-beat read -> outputs reach reset values at once; after release, ready=1, and with the macro all prior entries read back as zero.
